divider_32_bit: RTL and testbench
=================================

# divider_32_bit

Multi-cycle 32-bit integer divider for the miniRISC execute stage. It computes quotient and remainder by restoring division, one quotient bit per clock. Each trial subtraction reuses `adder_32_bit` as a subtractor (`b = ~divisor`, `c_in = 1`). The ALU control asserts `start`, stalls the pipeline while `busy` is high, and writes back on `done`.

## Interface
- None. Width is fixed at 32 to match `adder_32_bit`.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a division; sampled only in IDLE.
- `is_signed`  in  1  1 = two's-complement operands, 0 = unsigned; captured with `start`.
- `dividend`  in  32  numerator; captured with `start`.
- `divisor`  in  32  denominator; captured with `start`.
- `quotient`  out  32  registered result; holds until the next completion.
- `remainder`  out  32  registered result; holds until the next completion.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  single-cycle completion pulse.
- `div_by_zero`  out  1  registered with the results; 1 if the captured divisor was 0.

## Operation
- Reset (synchronous, `rst` = 1 at an edge):
  - state ← IDLE.
  - `quotient`, `remainder` ← 0.
  - `busy`, `done`, `div_by_zero` ← 0.
  - Iteration counter ← 0.
  - Reset has priority over every other event, including mid-operation; the in-flight operation is discarded and no `done` pulse follows.
- States:
  - **IDLE**: `start` = 1 moves to CALC. On the move:
    - Latch Q ← |dividend|, D ← |divisor|. Absolute values apply only when `is_signed` = 1; otherwise raw values.
    - Latch R ← 0, count ← 0.
    - Latch `neg_q` = `is_signed` & (dividend[31] ^ divisor[31]) & (divisor ≠ 0).
    - Latch `neg_r` = `is_signed` & dividend[31].
    - Latch `dz` = (divisor == 0).
  - **CALC**: one step per cycle, 32 steps.
    - Shift: S = {R[30:0], Q[31]}.
    - Trial: T = S − D, computed by `adder_32_bit(S, ~D, 1)`.
    - Accept when R[31] = 1 or the adder `c_out` = 1. On accept: R ← T, Q ← {Q[30:0], 1}. Otherwise: R ← S, Q ← {Q[30:0], 0}.
    - count increments each step; after the step with count = 31, move to FIX.
  - **FIX**: one cycle.
    - `quotient` ← `neg_q` ? −Q : Q.
    - `remainder` ← `neg_r` ? −R : R.
    - `div_by_zero` ← `dz`.
    - `done` ← 1; state → IDLE.
- Arithmetic rules:
  - Signed quotient truncates toward zero; remainder sign follows the dividend.
  - Divide by zero needs no special path. The algorithm yields Q = 0xFFFFFFFF and R = |dividend|. Signed mode reports quotient 0xFFFFFFFF (−1), because `neg_q` is forced to 0, and remainder = dividend.
  - Overflow 0x80000000 / 0xFFFFFFFF (signed): |dividend| = 2^31 as unsigned, result quotient 0x80000000, remainder 0, no flag.
- `start` while `busy` = 1 is ignored (operands not recaptured).
- Operand inputs may change freely after the capture edge.

## Timing
- Start accepted at edge E0. CALC occupies E1–E32. FIX occurs at E32→E33; results and `done` are registered at E33.
- Latency: `done` is high for exactly the one cycle following E33, i.e. 33 cycles after `start` is sampled. Latency is the same for every operand, including divide by zero.
- `busy`: rises at E0, falls at E33, the same edge `done` rises. `busy` and `done` are never high together.
- Back-to-back: `start` high during the `done` cycle is accepted at the next edge (state is IDLE). Results of the previous operation stay stable until the new operation's E33.
- `done` is a pulse, not a level. It falls one cycle later unless a new completion occurs, which is impossible within 33 cycles.

## Test plan
- Unsigned 100 / 7, `is_signed` = 0:
  - `busy` high 33 cycles.
  - `done` 33 cycles after start.
  - quotient = 14, remainder = 2, `div_by_zero` = 0.
- Signed 0xFFFFFFF9 (−7) / 2: quotient = 0xFFFFFFFD (−3), remainder = 0xFFFFFFFF (−1). Repeat 7 / 0xFFFFFFFE → quotient 0xFFFFFFFD, remainder 1.
- Divide by zero:
  - Unsigned 0x00001234 / 0 → quotient 0xFFFFFFFF, remainder 0x00001234, `div_by_zero` = 1.
  - Signed 0xFFFFFF00 / 0 → quotient 0xFFFFFFFF, remainder 0xFFFFFF00.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0, `div_by_zero` = 0. Unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- Reset 10 cycles into a 100 / 7 operation:
  - Next cycle: `busy` = 0, all outputs 0.
  - No `done` within 40 cycles.
  - A subsequent start of 9 / 3 completes normally with quotient 3, remainder 0.
- Start pulsed again while busy with 50 / 5 is ignored; the first result, 100 / 7, is unchanged. A start asserted during the `done` cycle is accepted and completes 33 cycles later.

Source files
------------

// File: rtl/divider_32_bit_if.sv
// Handshake and operand/result bundle between the miniRISC ALU control and the divider.
interface divider_32_bit_if;
   logic        start;
   logic        is_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        busy;
   logic        done;
   logic        div_by_zero;

   modport master (
      output start, is_signed, dividend, divisor,
      input  quotient, remainder, busy, done, div_by_zero
   );

   modport slave (
      input  start, is_signed, dividend, divisor,
      output quotient, remainder, busy, done, div_by_zero
   );
endinterface

// File: rtl/divider_32_bit.sv
// Multi-cycle restoring divider: one quotient bit per clock, the trial subtraction
// runs through adder_32_bit, with sign fix-up applied in a final cycle.
module adder_32_bit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        c_in,
   output logic [31:0] sum,
   output logic        c_out
);
   assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {32'd0, c_in};
endmodule

module divider_32_bit (
   input logic             clk,
   input logic             rst,
   divider_32_bit_if.slave divBus
);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t      state_q, state_d;
   logic [31:0] quotAcc_q, quotAcc_d;
   logic [31:0] partRem_q, partRem_d;
   logic [31:0] divisorAbs_q, divisorAbs_d;
   logic [4:0]  count_q, count_d;
   logic        negQuot_q, negQuot_d;
   logic        negRem_q, negRem_d;
   logic        divZero_q, divZero_d;
   logic [31:0] quotient_q, quotient_d;
   logic [31:0] remainder_q, remainder_d;
   logic        dzOut_q, dzOut_d;
   logic        done_q, done_d;

   logic [31:0] shifted;
   logic [31:0] trial;
   logic        trialCarry;
   logic        accept;

   assign shifted = {partRem_q[30:0], quotAcc_q[31]};

   adder_32_bit trialSub (
      .a     (shifted),
      .b     (~divisorAbs_q),
      .c_in  (1'b1),
      .sum   (trial),
      .c_out (trialCarry)
   );

   // The bit shifted out of R[31] is the 33rd bit of S, so S >= D regardless of the carry.
   assign accept = partRem_q[31] | trialCarry;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         quotAcc_q    <= '0;
         partRem_q    <= '0;
         divisorAbs_q <= '0;
         count_q      <= '0;
         negQuot_q    <= 1'b0;
         negRem_q     <= 1'b0;
         divZero_q    <= 1'b0;
         quotient_q   <= '0;
         remainder_q  <= '0;
         dzOut_q      <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         quotAcc_q    <= quotAcc_d;
         partRem_q    <= partRem_d;
         divisorAbs_q <= divisorAbs_d;
         count_q      <= count_d;
         negQuot_q    <= negQuot_d;
         negRem_q     <= negRem_d;
         divZero_q    <= divZero_d;
         quotient_q   <= quotient_d;
         remainder_q  <= remainder_d;
         dzOut_q      <= dzOut_d;
         done_q       <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (divBus.start) state_d = CALC;
         CALC:    if (count_q == 5'd31) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      quotAcc_d    = quotAcc_q;
      partRem_d    = partRem_q;
      divisorAbs_d = divisorAbs_q;
      count_d      = count_q;
      negQuot_d    = negQuot_q;
      negRem_d     = negRem_q;
      divZero_d    = divZero_q;
      quotient_d   = quotient_q;
      remainder_d  = remainder_q;
      dzOut_d      = dzOut_q;
      done_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (divBus.start) begin
               quotAcc_d    = (divBus.is_signed && divBus.dividend[31]) ? -divBus.dividend : divBus.dividend;
               divisorAbs_d = (divBus.is_signed && divBus.divisor[31])  ? -divBus.divisor  : divBus.divisor;
               partRem_d    = '0;
               count_d      = '0;
               // A zero divisor keeps the all-ones quotient unsigned so signed mode reports -1.
               negQuot_d    = divBus.is_signed & (divBus.dividend[31] ^ divBus.divisor[31])
                              & (divBus.divisor != 32'd0);
               negRem_d     = divBus.is_signed & divBus.dividend[31];
               divZero_d    = (divBus.divisor == 32'd0);
            end
         end
         CALC: begin
            partRem_d = accept ? trial : shifted;
            quotAcc_d = {quotAcc_q[30:0], accept};
            count_d   = count_q + 5'd1;
         end
         FIX: begin
            quotient_d  = negQuot_q ? -quotAcc_q : quotAcc_q;
            remainder_d = negRem_q  ? -partRem_q : partRem_q;
            dzOut_d     = divZero_q;
            done_d      = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      divBus.busy        = (state_q != IDLE);
      divBus.done        = done_q;
      divBus.quotient    = quotient_q;
      divBus.remainder   = remainder_q;
      divBus.div_by_zero = dzOut_q;
   end
endmodule

// File: tb/tb_divider_32_bit.sv
// Directed self-checking bench for divider_32_bit: hand-computed vectors covering
// unsigned/signed division, divide by zero, overflow, reset abort and start handling.
module tb_divider_32_bit;
   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   latency;
   int   busyCnt;
   int   doneSeen;

   divider_32_bit_if divBus ();

   divider_32_bit dut (
      .clk    (clk),
      .rst    (rst),
      .divBus (divBus.slave)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Called at a negedge; presents one start cycle, then scrambles the operands.
   task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      divBus.start     = 1'b1;
      divBus.is_signed = sgn;
      divBus.dividend  = a;
      divBus.divisor   = b;
      @(negedge clk);
      divBus.start     = 1'b0;
      divBus.is_signed = ~sgn;
      divBus.dividend  = $urandom;
      divBus.divisor   = $urandom;
   endtask

   // Bounded wait for done; reports cycles elapsed and busy-high cycles seen.
   task automatic waitDone(output int cycles, output int busyCycles);
      cycles = 0;
      busyCycles = 0;
      while (divBus.done !== 1'b1 && cycles < 100) begin
         if (divBus.busy === 1'b1) busyCycles++;
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic checkResult(input string tag, input logic [31:0] q, input logic [31:0] r, input logic dz);
      checkOutput({tag, "_quot"}, divBus.quotient, q);
      checkOutput({tag, "_rem"}, divBus.remainder, r);
      checkOutput({tag, "_dz"}, {31'd0, divBus.div_by_zero}, {31'd0, dz});
   endtask

   // Directed sequence: each step drives at a negedge and samples at later negedges.
   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      divBus.start = 1'b0;
      divBus.is_signed = 1'b0;
      divBus.dividend = '0;
      divBus.divisor = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checkResult("reset", 32'd0, 32'd0, 1'b0);
      checkOutput("reset_busy", {31'd0, divBus.busy}, 32'd0);
      checkOutput("reset_done", {31'd0, divBus.done}, 32'd0);

      applyStimulus(1'b0, 32'd100, 32'd7);
      checkOutput("u100_7_busy_rise", {31'd0, divBus.busy}, 32'd1);
      waitDone(latency, busyCnt);
      checkOutput("u100_7_latency", latency, 32'd33);
      checkOutput("u100_7_busycnt", busyCnt, 32'd33);
      checkOutput("u100_7_busy_at_done", {31'd0, divBus.busy}, 32'd0);
      checkResult("u100_7", 32'd14, 32'd2, 1'b0);
      @(negedge clk);
      checkOutput("u100_7_done_pulse", {31'd0, divBus.done}, 32'd0);

      applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2);
      waitDone(latency, busyCnt);
      checkOutput("sm7_2_latency", latency, 32'd33);
      checkResult("sm7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);

      applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE);
      waitDone(latency, busyCnt);
      checkResult("s7_m2", 32'hFFFF_FFFD, 32'd1, 1'b0);

      applyStimulus(1'b0, 32'h0000_1234, 32'd0);
      waitDone(latency, busyCnt);
      checkOutput("udz_latency", latency, 32'd33);
      checkResult("udz", 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);

      applyStimulus(1'b1, 32'hFFFF_FF00, 32'd0);
      waitDone(latency, busyCnt);
      checkResult("sdz", 32'hFFFF_FFFF, 32'hFFFF_FF00, 1'b1);

      applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      waitDone(latency, busyCnt);
      checkResult("sovf", 32'h8000_0000, 32'd0, 1'b0);

      applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1);
      waitDone(latency, busyCnt);
      checkResult("umax_1", 32'hFFFF_FFFF, 32'd0, 1'b0);
      @(negedge clk);

      applyStimulus(1'b0, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkResult("abort", 32'd0, 32'd0, 1'b0);
      checkOutput("abort_busy", {31'd0, divBus.busy}, 32'd0);
      doneSeen = 0;
      for (int i = 0; i < 40; i++) begin
         if (divBus.done === 1'b1) doneSeen++;
         @(negedge clk);
      end
      checkOutput("abort_no_done", doneSeen, 32'd0);
      applyStimulus(1'b0, 32'd9, 32'd3);
      waitDone(latency, busyCnt);
      checkOutput("u9_3_latency", latency, 32'd33);
      checkResult("u9_3", 32'd3, 32'd0, 1'b0);
      @(negedge clk);

      applyStimulus(1'b0, 32'd100, 32'd7);
      repeat (5) @(negedge clk);
      divBus.start    = 1'b1;
      divBus.dividend = 32'd50;
      divBus.divisor  = 32'd5;
      @(negedge clk);
      divBus.start    = 1'b0;
      waitDone(latency, busyCnt);
      checkOutput("ignored_start_latency", latency, 32'd27);
      checkResult("ignored_start", 32'd14, 32'd2, 1'b0);

      applyStimulus(1'b0, 32'd50, 32'd5);
      checkOutput("b2b_busy", {31'd0, divBus.busy}, 32'd1);
      checkOutput("b2b_hold_quot", divBus.quotient, 32'd14);
      waitDone(latency, busyCnt);
      checkOutput("b2b_latency", latency, 32'd33);
      checkResult("b2b", 32'd10, 32'd0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
